// File: rtl/mult_pkg.sv
// Shared constants and helpers for the shift-and-add multiplier datapath.
package mult_pkg;

    localparam int unsigned MULT_N = 4;

    // Ceiling log2, with a floor of 1 so a counter always has at least one bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        while ((32'd1 << res) < value) begin
            res = res + 1;
        end
        return (res == 0) ? 1 : res;
    endfunction

endpackage

// File: rtl/mult_datapath_if.sv
// Strobe/operand/result bundle between the multiplier control FSM and its datapath.
interface mult_datapath_if
    import mult_pkg::*;
#(
    parameter int unsigned N = MULT_N
);

    logic           Load;
    logic           Ad;
    logic           Sh;
    logic [N-1:0]   Mcand;
    logic [N-1:0]   Mplier;
    logic           M;
    logic           K;
    logic [2*N-1:0] Product;

    modport master (
        output Load, Ad, Sh, Mcand, Mplier,
        input  M, K, Product
    );

    modport slave (
        input  Load, Ad, Sh, Mcand, Mplier,
        output M, K, Product
    );

endinterface

// File: rtl/mult_shift_cnt.sv
// Mod-N shift counter; tc_c flags the last shift of a multiply.
module mult_shift_cnt
    import mult_pkg::*;
#(
    parameter int unsigned N = MULT_N
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    output logic tc_c
);

    localparam int unsigned CNT_W = clog2(N);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc_c = (cnt_q == CNT_W'(N - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc_c ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/mult_datapath.sv
// Shift-and-add multiplier datapath: accumulator, multiplicand register and shift counter.
// Optional MULT_DP_RESULT_HOLD_EN adds a result register that holds Product between completions.
module mult_datapath
    import mult_pkg::*;
#(
    parameter int unsigned N = MULT_N
) (
    input  logic                  Clk,
    input  logic                  Rst,
    mult_datapath_if.slave        bus
);

    localparam int unsigned ACC_W = 2 * N + 1;
    localparam int unsigned P_W   = 2 * N;

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [N-1:0]     mc_q;
    logic [N-1:0]     mc_d;
    logic [N:0]       sum_c;
    logic             k_c;
    logic             sh_en_c;

    // Shift only when no higher-priority action claims the edge.
    assign sh_en_c = bus.Sh & ~bus.Ad & ~bus.Load & ~Rst;
    assign sum_c   = {1'b0, acc_q[2*N-1:N]} + {1'b0, mc_q};

    mult_shift_cnt #(.N(N)) u_cnt (
        .clk  (Clk),
        .clr  (Rst | bus.Load),
        .en   (sh_en_c),
        .tc_c (k_c)
    );

    always_comb begin
        acc_d = acc_q;
        mc_d  = mc_q;
        if (Rst) begin
            acc_d = '0;
            mc_d  = '0;
        end else if (bus.Load) begin
            acc_d = {{(N + 1){1'b0}}, bus.Mplier};
            mc_d  = bus.Mcand;
        end else if (bus.Ad) begin
            acc_d[2*N:N] = sum_c;
        end else if (bus.Sh) begin
            acc_d = {1'b0, acc_q[2*N:1]};
        end
    end

    always_ff @(posedge Clk) begin
        acc_q <= acc_d;
        mc_q  <= mc_d;
    end

    assign bus.M = acc_q[0];
    assign bus.K = k_c;

`ifdef MULT_DP_RESULT_HOLD_EN
    logic [P_W-1:0] res_q;
    logic [P_W-1:0] res_d;

    // Capture the post-shift accumulator on the completing shift.
    always_comb begin
        res_d = res_q;
        if (Rst) begin
            res_d = '0;
        end else if (sh_en_c && k_c) begin
            res_d = acc_d[P_W-1:0];
        end
    end

    always_ff @(posedge Clk) begin
        res_q <= res_d;
    end

    assign bus.Product = res_q;
`else
    assign bus.Product = acc_q[P_W-1:0];
`endif

endmodule

// File: tb/tb_mult_datapath.sv
// Directed, table-driven bench for mult_datapath at N = 4 (honours MULT_DP_RESULT_HOLD_EN).
module tb_mult_datapath;

    localparam int unsigned N = 4;

    typedef struct {
        logic [3:0] mcand;
        logic [3:0] mplier;
        logic [7:0] prod;
        logic [3:0] m_seq;
    } vec_t;

    logic Clk;
    logic Rst;
    int   n_cmp;
    int   n_err;
    vec_t vecs [5];

    mult_datapath_if #(.N(N)) bus ();

    mult_datapath #(.N(N)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic l, input logic a, input logic s,
                        input logic [3:0] mc, input logic [3:0] mp);
        bus.Load   = l;
        bus.Ad     = a;
        bus.Sh     = s;
        bus.Mcand  = mc;
        bus.Mplier = mp;
        @(posedge Clk);
        #1;
        bus.Load = 1'b0;
        bus.Ad   = 1'b0;
        bus.Sh   = 1'b0;
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
    endtask

    // One bit of the FSM loop: optional add, then shift, checking M and K.
    task automatic bit_step(input int i, input logic m_exp, input logic k_exp);
        chk("M", 16'(bus.M), 16'(m_exp));
        if (m_exp) step(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        chk("K", 16'(bus.K), 16'(k_exp));
        step(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
    endtask

    task automatic run_mult(input logic [3:0] mc, input logic [3:0] mp,
                            input logic [7:0] prod, input logic [3:0] m_seq);
        step(1'b1, 1'b0, 1'b0, mc, mp);
        for (int i = 0; i < int'(N); i++) begin
            bit_step(i, m_seq[i], i == int'(N) - 1);
        end
        chk("product", 16'(bus.Product), 16'(prod));
        chk("K_after", 16'(bus.K), 16'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        Rst = 1'b0;
        bus.Load = 1'b0; bus.Ad = 1'b0; bus.Sh = 1'b0;
        bus.Mcand = '0;  bus.Mplier = '0;

        vecs[0] = '{4'd13, 4'd11, 8'h8F, 4'b1011};
        vecs[1] = '{4'd15, 4'd15, 8'hE1, 4'b1111};
        vecs[2] = '{4'd0,  4'd9,  8'h00, 4'b1001};
        vecs[3] = '{4'd9,  4'd0,  8'h00, 4'b0000};
        vecs[4] = '{4'd7,  4'd6,  8'd42, 4'b0110};

        do_reset();
        chk("rst_M", 16'(bus.M), 16'd0);
        chk("rst_K", 16'(bus.K), 16'd0);
        chk("rst_product", 16'(bus.Product), 16'd0);

        foreach (vecs[v]) begin
            run_mult(vecs[v].mcand, vecs[v].mplier, vecs[v].prod, vecs[v].m_seq);
        end

        // Reset after the 2nd shift of 7 x 6 aborts the multiply.
        step(1'b1, 1'b0, 1'b0, 4'd7, 4'd6);
        bit_step(0, 1'b0, 1'b0);
        bit_step(1, 1'b1, 1'b0);
        do_reset();
        chk("abort_product", 16'(bus.Product), 16'd0);
        chk("abort_M", 16'(bus.M), 16'd0);
        chk("abort_K", 16'(bus.K), 16'd0);
        run_mult(4'd7, 4'd6, 8'd42, 4'b0110);

        // Load mid-operation restarts the counter and operands.
        step(1'b1, 1'b0, 1'b0, 4'd12, 4'd10);
        bit_step(0, 1'b0, 1'b0);
        bit_step(1, 1'b1, 1'b0);
        run_mult(4'd3, 4'd5, 8'd15, 4'b0101);

        // Result hold across a following multiply.
        run_mult(4'd13, 4'd11, 8'h8F, 4'b1011);
        step(1'b1, 1'b0, 1'b0, 4'd2, 4'd2);
`ifdef MULT_DP_RESULT_HOLD_EN
        chk("hold_after_load", 16'(bus.Product), 16'h8F);
`else
        chk("live_after_load", 16'(bus.Product), 16'h02);
`endif
        for (int i = 0; i < int'(N); i++) begin
            logic [3:0] seq;
            seq = 4'b0010;
`ifdef MULT_DP_RESULT_HOLD_EN
            chk("hold_mid", 16'(bus.Product), 16'h8F);
`endif
            bit_step(i, seq[i], i == int'(N) - 1);
        end
        chk("second_product", 16'(bus.Product), 16'd4);

        // Extra shifts wrap the counter; K pulses again on the 4th.
        for (int i = 0; i < int'(N); i++) begin
            chk("wrap_K", 16'(bus.K), 16'(i == int'(N) - 1));
            step(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
        end
        chk("wrap_K_end", 16'(bus.K), 16'd0);

        // Priority: Load beats Ad, Ad beats Sh (no shift, no count).
        step(1'b1, 1'b1, 1'b0, 4'd3, 4'd5);
        chk("prio_load_M", 16'(bus.M), 16'd1);
        step(1'b0, 1'b1, 1'b1, 4'd0, 4'd0);
        chk("prio_ad_M", 16'(bus.M), 16'd1);
`ifndef MULT_DP_RESULT_HOLD_EN
        chk("prio_ad_acc", 16'(bus.Product), 16'h35);
`endif
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
        chk("prio_cnt_K", 16'(bus.K), 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
